// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial sync-pattern transmitter (seq_gen)
// and its receive-side counterpart (seq_dec).
//   state_t      : frame FSM states
//   SYNC_PATTERN : default sync pattern, transmitted MSB-first
//   SYNC_W       : width of SYNC_PATTERN
//   clog2        : ceiling log2 for sizing counters at elaboration time
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        PAY  = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam int unsigned SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1101;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: payload valid/ready handshake into seq_gen.
//   in_valid : payload offered (producer -> seq_gen)
//   in_data  : payload word, sampled only on an accept cycle
//   in_ready : seq_gen can accept a payload this cycle
// Modports: master = payload producer, slave = seq_gen.
interface seq_gen_if #(
    parameter int unsigned PAYLOAD_W = 8
);

    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial frame transmitter.
// Frame on tx_bit: PATTERN (MSB-first), payload (MSB-first), odd-parity bit,
// then GAP_CYCLES forced zeros. One bit per clock.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   in_if      : payload handshake (slave side: in_valid, in_data, in_ready)
//   tx_bit     : serial data out, registered
//   tx_active  : high while sync, payload or parity bit is on tx_bit, registered
//   frame_done : one-cycle pulse coincident with the parity bit, registered
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W      = SYNC_W,
    parameter logic [PAT_W-1:0] PATTERN = SYNC_PATTERN,
    parameter int unsigned PAYLOAD_W  = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    seq_gen_if.slave    in_if,
    output logic        tx_bit,
    output logic        tx_active,
    output logic        frame_done
);

    localparam int unsigned MAX_A = (PAT_W > PAYLOAD_W) ? PAT_W : PAYLOAD_W;
    localparam int unsigned MAX_N = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned CNT_W = (clog2(MAX_N + 1) < 1) ? 1 : clog2(MAX_N + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0] sr_q, sr_d;
    logic                 par_q, par_d;
    logic                 tx_bit_q, tx_bit_d;
    logic                 tx_active_q, tx_active_d;
    logic                 frame_done_q, frame_done_d;
    logic                 in_ready_q, in_ready_d;
    logic [PAT_W-1:0]     pat_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            par_q        <= 1'b0;
            tx_bit_q     <= 1'b0;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            par_q        <= par_d;
            tx_bit_q     <= tx_bit_d;
            tx_active_q  <= tx_active_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Next-state and datapath. cnt counts down the bits still to emit in the
    // current field and reloads on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        par_d   = par_q;

        unique case (state_q)
            IDLE: begin
                if (in_if.in_valid && in_ready_q) begin
                    state_d = PRE;
                    cnt_d   = CNT_W'(PAT_W - 1);
                    sr_d    = in_if.in_data;
                    par_d   = ~^in_if.in_data;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    state_d = PAY;
                    cnt_d   = CNT_W'(PAYLOAD_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PAY: begin
                if (cnt_q == '0) begin
                    state_d = PAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    sr_d  = sr_q << 1;
                end
            end
            PAR: begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered tx_bit shows
    // the first sync bit in the cycle right after the accept edge.
    assign pat_shift = PATTERN >> cnt_d;

    always_comb begin
        tx_bit_d     = 1'b0;
        tx_active_d  = 1'b0;
        frame_done_d = 1'b0;
        in_ready_d   = 1'b0;

        unique case (state_d)
            IDLE: in_ready_d = 1'b1;
            PRE: begin
                tx_bit_d    = pat_shift[0];
                tx_active_d = 1'b1;
            end
            PAY: begin
                tx_bit_d    = sr_d[PAYLOAD_W-1];
                tx_active_d = 1'b1;
            end
            PAR: begin
                tx_bit_d     = par_d;
                tx_active_d  = 1'b1;
                frame_done_d = 1'b1;
            end
            GAP: ;
            default: ;
        endcase
    end

    assign tx_bit         = tx_bit_q;
    assign tx_active      = tx_active_q;
    assign frame_done     = frame_done_q;
    assign in_if.in_ready = in_ready_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed, table-driven bench for seq_gen with default
// parameters (PATTERN 1101, PAYLOAD_W 8, GAP_CYCLES 2).
module tb_seq_gen;

    logic clk;
    logic reset;
    logic tx_bit;
    logic tx_active;
    logic frame_done;

    int unsigned checks;
    int unsigned errors;

    seq_gen_if #(.PAYLOAD_W(8)) bus ();

    seq_gen #(
        .PAT_W      (4),
        .PATTERN    (4'b1101),
        .PAYLOAD_W  (8),
        .GAP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [12:0] word;   // sync, payload, parity as seen on tx_bit, first bit in MSB
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Returns at a negedge with in_ready sampled high, or flags a timeout.
    task automatic wait_ready(input string name);
        int unsigned n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            check({name, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [12:0] exp_word, input string name);
        logic [12:0] word;
        logic [12:0] done;
        int unsigned act;
        logic        rdy_seen;
        logic        gap_any;

        wait_ready(name);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;      // mid-frame data changes must not leak into the frame
        word = '0;
        done = '0;
        act = 0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            word = {word[11:0], tx_bit};
            done = {done[11:0], frame_done};
            if (tx_active === 1'b1) act++;
            if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
        end
        check({name, "_word"}, 32'(word), 32'(exp_word));
        check({name, "_done_pos"}, 32'(done), 32'd1);
        check({name, "_active_cnt"}, act, 32'd13);
        check({name, "_ready_busy"}, 32'(rdy_seen), 32'd0);
        gap_any = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ((tx_bit | tx_active | frame_done | bus.in_ready) !== 1'b0) gap_any = 1'b1;
        end
        check({name, "_gap"}, 32'(gap_any), 32'd0);
        @(negedge clk);
        check({name, "_idle_ready"}, {30'd0, bus.in_ready, tx_bit}, 32'b10);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{data: 8'h00, word: 13'b1101_00000000_1};
        vecs[1] = '{data: 8'hA5, word: 13'b1101_10100101_1};
        vecs[2] = '{data: 8'h07, word: 13'b1101_00000111_0};
        vecs[3] = '{data: 8'hFF, word: 13'b1101_11111111_1};
        vecs[4] = '{data: 8'h80, word: 13'b1101_10000000_0};
        vecs[5] = '{data: 8'h3C, word: 13'b1101_00111100_1};

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, tx_bit, tx_active, frame_done, bus.in_ready}, 32'd0);

        // in_valid offered before in_ready: the first edge after release must not accept
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("ready_low_after_release", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("first_edge_ready", {30'd0, bus.in_ready, tx_active}, 32'b10);
        bus.in_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].data, vecs[i].word, $sformatf("vec%0d", i));
        end

        // in_valid held high: 00 then FF, separated by gap plus the IDLE accept cycle
        begin
            logic [28:0] txv;
            logic [28:0] actv;
            logic [28:0] rdyv;
            int unsigned overlap;
            wait_ready("b2b");
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h00;
            @(posedge clk);
            #1;
            bus.in_data = 8'hFF;
            txv = '0;
            actv = '0;
            rdyv = '0;
            overlap = 0;
            for (int i = 0; i < 29; i++) begin
                @(negedge clk);
                txv  = {txv[27:0], tx_bit};
                actv = {actv[27:0], tx_active};
                rdyv = {rdyv[27:0], bus.in_ready};
                if (bus.in_ready === 1'b1 && tx_active === 1'b1) overlap++;
            end
            bus.in_valid = 1'b0;
            check("b2b_tx", 32'(txv), 32'({13'b1101_00000000_1, 3'b000, 13'b1101_11111111_1}));
            check("b2b_active", 32'(actv), 32'({13'h1FFF, 3'b000, 13'h1FFF}));
            check("b2b_ready", 32'(rdyv), 32'(29'b1 << 13));
            check("b2b_overlap", overlap, 32'd0);
        end

        // Reset during payload bit 3 of an FF frame (tx_bit would be 1)
        begin
            logic done_seen;
            wait_ready("rst");
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hFF;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            for (int i = 0; i < 8; i++) @(negedge clk);
            check("rst_pre_tx", {30'd0, tx_bit, tx_active}, 32'b11);
            reset = 1'b0;
            #1;
            check("rst_async", {28'd0, tx_bit, tx_active, frame_done, bus.in_ready}, 32'd0);
            done_seen = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (frame_done !== 1'b0 || tx_bit !== 1'b0) done_seen = 1'b1;
            end
            reset = 1'b1;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (frame_done !== 1'b0 || tx_active !== 1'b0) done_seen = 1'b1;
            end
            check("rst_no_done", 32'(done_seen), 32'd0);
            run_frame(8'h00, 13'b1101_00000000_1, "post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial frame transmitter; the transmit-side counterpart of the team's overlapping sync-pattern detector (seq_dec).
- Accepts a parallel payload over a valid/ready handshake and emits one bit per clock on tx_bit.
- Frame format: sync pattern (default 1101), then payload MSB-first, then an odd-parity bit, then a minimum idle gap of zeros.
- Drives the serial line consumed by seq_dec in loopback and system tests.

Parameters:
- PATTERN, 4'b1101: sync pattern, transmitted MSB-first.
- PAT_W, 4: width of PATTERN in bits. Range 2..8.
- PAYLOAD_W, 8: payload width in bits. Range 1..32.
- GAP_CYCLES, 2: number of forced zero bits after each parity bit. Minimum 1.

Ports:
- clk  input  1  System clock; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-low reset. Asserted when 0.
- in_valid  input  1  Payload offered.
- in_data  input  PAYLOAD_W  Payload word. Sampled only on an accept cycle.
- in_ready  output  1  Block can accept a payload this cycle.
- tx_bit  output  1  Serial data out, registered.
- tx_active  output  1  High while a preamble, payload or parity bit is on tx_bit, registered.
- frame_done  output  1  One-cycle pulse, registered, coincident with the parity bit on tx_bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters and the shift register cleared.
  - tx_bit=0, tx_active=0, frame_done=0, in_ready=0.
  - in_ready rises to 1 on the first clock edge after reset is released.
- in_ready is registered and equals 1 only in IDLE.
- Accept cycle: in_valid && in_ready at a clock edge.
  - Latch in_data into the shift register.
  - Compute parity = ~^in_data, so the total ones in payload plus parity bit is odd.
  - Go to PRE.
  - in_ready falls on the same edge.
- Latency: the first PATTERN bit (PATTERN[PAT_W-1]) appears on tx_bit in the cycle after the accept edge.
- PRE:
  - Emit PATTERN MSB-first over PAT_W cycles, with tx_active=1.
  - Move to PAY after bit 0 is emitted.
- PAY:
  - Emit PAYLOAD_W bits, shift register MSB first, with tx_active=1.
  - Then go to PAR.
- PAR:
  - Emit one parity bit with tx_active=1 and frame_done=1.
  - Then go to GAP.
- GAP:
  - Emit GAP_CYCLES zeros with tx_active=0.
  - Then go to IDLE.
- IDLE: tx_bit=0, tx_active=0.
- Total frame: PAT_W+PAYLOAD_W+1 active bits, followed by at least GAP_CYCLES zeros.
  - Back-to-back frames are separated by GAP_CYCLES+1 zero cycles: the gap plus the one IDLE accept cycle.
- in_valid while not ready is ignored. in_data is don't-care outside accept cycles, and changes to it mid-frame have no effect.
- in_valid held high continuously: a new frame is accepted on the IDLE cycle immediately after GAP completes.
- Bit counter: width clog2(max(PAT_W,PAYLOAD_W,GAP_CYCLES)+1). It reloads on every state entry and never wraps inside a state.
- Reset asserted mid-frame: output goes to 0 immediately (asynchronously), the frame is abandoned, and no frame_done is emitted.
- Illegal state encodings recover to IDLE on the next edge with tx_bit=0.
- The payload is not bit-stuffed. A payload that contains PATTERN, or forms it across a field boundary, can cause an extra detection at the receiver. This is accepted and documented for users.

Decomposition:
- Package seq_pkg holds:
  - state enum: IDLE, PRE, PAY, PAR, GAP;
  - default SYNC_PATTERN=4'b1101 and SYNC_W=4, shared with seq_dec;
  - a clog2 helper function.
- No sub-module is required: a single FSM plus a datapath of shift register, bit counter and parity register.

Test Plan:
- Reset, then in_data=8'h00 with in_valid=1 → tx_bit sequence 1,1,0,1, then 0×8, then 1 (parity) with frame_done=1 on the parity bit; tx_active high for exactly 13 cycles; then 0,0 gap; then in_ready=1.
- in_data=8'hA5 → payload bits 1,0,1,0,0,1,0,1 follow the pattern; parity bit=1.
- in_data=8'h07 → parity bit=0.
- in_valid held high with payloads 8'h00 then 8'hFF → frames separated by exactly 3 zero cycles; second parity bit=1; in_ready never high while tx_active=1.
- Reset pulled low during payload bit 3 → tx_bit=0, tx_active=0 and in_ready=0 immediately; no frame_done. After release, a new 8'h00 frame is output intact.
- Loopback into seq_dec, 10 frames of payload 8'h00 → detected pulses exactly once per frame, one cycle after the fourth pattern bit.
